// File: rtl/seg_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_shift_ctrl
// Purpose  : Serialises a 64-bit, 8-digit segment image into an external
//            shift-register chain. The chain is cleared first. The 64 bits are
//            then sent MSB first, and the output latch is strobed at the end.
//            A free-running flash divider drives the decoder blink input.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            start    - transfer request, sampled only in IDLE
//            seg_txt  - 64-bit segment image, captured at start
//            s_clk    - serial shift clock (low DIV cycles, high DIV cycles)
//            s_data   - serial data, stable across each s_clk rising edge
//            s_clr_n  - chain clear, active-low, one cycle before shifting
//            s_latch  - output-latch strobe, one cycle after the last bit
//            busy     - high from CLEAR through LATCH
//            done     - one-cycle completion pulse, coincident with s_latch
//            flash    - blink enable, period 2*FLASH_DIV cycles
// Revision : 1.0 - initial release
// ============================================================================
module seg_shift_ctrl #(
  parameter int DIV       = 2,
  parameter int FLASH_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] seg_txt,
  output logic        s_clk,
  output logic        s_data,
  output logic        s_clr_n,
  output logic        s_latch,
  output logic        busy,
  output logic        done,
  output logic        flash
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
  localparam logic [6:0] LAST_BIT   = 7'd63;
  localparam int         FCW        = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);
  localparam logic [FCW-1:0] FLASH_ONE  = FCW'(1);

  state_t      state_q;
  logic [63:0] sreg_q;
  logic [6:0]  bit_cnt_q;
  logic [7:0]  div_q;
  logic        s_clk_q;
  logic        s_data_q;
  logic        s_clr_n_q;
  logic        s_latch_q;
  logic        done_q;

  logic [FCW-1:0] fcnt_q;
  logic [FCW-1:0] fcnt_d;
  logic           flash_q;
  logic           flash_d;

  // --------------------------------------------------------------------------
  // Transfer FSM. All outputs are registered and are updated on the same edge
  // as the state, so each output level belongs to the state it is shown in.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      s_clk_q   <= 1'b0;
      s_data_q  <= 1'b0;
      s_clr_n_q <= 1'b1;
      s_latch_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Single-cycle strobes default to their inactive level.
      s_clr_n_q <= 1'b1;
      s_latch_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sreg_q    <= seg_txt;
            s_clr_n_q <= 1'b0;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // Present bit 63 at the start of the first low phase.
          div_q     <= '0;
          bit_cnt_q <= '0;
          s_clk_q   <= 1'b0;
          s_data_q  <= sreg_q[63];
          state_q   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!s_clk_q) begin
              s_clk_q <= 1'b1;
            end else begin
              // End of a high phase: the bit has been clocked into the chain.
              s_clk_q <= 1'b0;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                s_data_q  <= 1'b0;
                s_latch_q <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= ST_LATCH;
              end else begin
                // The next bit changes only here, at the start of a low phase.
                bit_cnt_q <= bit_cnt_q + 7'd1;
                sreg_q    <= {sreg_q[62:0], 1'b0};
                s_data_q  <= sreg_q[62];
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        ST_LATCH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Flash divider: free-running and independent of the transfer FSM.
  // --------------------------------------------------------------------------
  always_comb begin
    fcnt_d  = fcnt_q + FLASH_ONE;
    flash_d = flash_q;
    if (fcnt_q == FLASH_LAST) begin
      fcnt_d  = '0;
      flash_d = ~flash_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      flash_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
    end
  end

  assign s_clk   = s_clk_q;
  assign s_data  = s_data_q;
  assign s_clr_n = s_clr_n_q;
  assign s_latch = s_latch_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);
  assign flash   = flash_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_shift_ctrl
// Purpose  : Directed self-checking bench for seg_shift_ctrl. dut2 uses DIV=2
//            and FLASH_DIV=4. dut1 uses DIV=1 for back-to-back transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_shift_ctrl;

  localparam logic [63:0] PAT = 64'hC0F9_A4B0_9992_82F8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start1;
  logic [63:0] seg_txt2, seg_txt1;
  logic        s_clk2, s_data2, s_clr_n2, s_latch2, busy2, done2, flash2;
  logic        s_clk1, s_data1, s_clr_n1, s_latch1, busy1, done1, flash1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_shift_ctrl #(.DIV(2), .FLASH_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .seg_txt(seg_txt2),
    .s_clk(s_clk2), .s_data(s_data2), .s_clr_n(s_clr_n2), .s_latch(s_latch2),
    .busy(busy2), .done(done2), .flash(flash2)
  );

  seg_shift_ctrl #(.DIV(1), .FLASH_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seg_txt(seg_txt1),
    .s_clk(s_clk1), .s_data(s_data1), .s_clr_n(s_clr_n1), .s_latch(s_latch1),
    .busy(busy1), .done(done1), .flash(flash1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one dut2 transfer. Start is sampled at edge N, and the observations
  // are indexed by cycle number k relative to N. This task only measures.
  task automatic xfer2(input logic [63:0] pat, input bit chg, input bit restart,
                       output logic [63:0] got, output int edges, output int done_cyc,
                       output int ndone, output int latch_mis, output int viol,
                       output logic busy259, output bit rebusy, output bit clr_ok);
    logic prev_clk, prev_data;
    seg_txt2 = pat;
    start2   = 1'b1;
    tick();
    start2   = 1'b0;
    clr_ok    = (s_clr_n2 === 1'b0) && (busy2 === 1'b1) && (s_clk2 === 1'b0);
    got       = '0;
    edges     = 0;
    done_cyc  = -1;
    ndone     = 0;
    latch_mis = 0;
    viol      = 0;
    busy259   = 1'bx;
    rebusy    = 1'b0;
    prev_clk  = s_clk2;
    prev_data = s_data2;
    for (int k = 2; k <= 262; k++) begin
      if (chg && k == 10) seg_txt2 = '1;
      if (restart && k == 100) start2 = 1'b1;
      if (restart && k == 101) start2 = 1'b0;
      tick();
      if (s_clk2 === 1'b1 && prev_clk === 1'b0) begin
        got   = {got[62:0], s_data2};
        edges = edges + 1;
      end
      // Data may move only in the first SHIFT cycle or right after s_clk falls.
      if (s_data2 !== prev_data && !(k == 2 || (s_clk2 === 1'b0 && prev_clk === 1'b1)))
        viol = viol + 1;
      if (done2 === 1'b1) begin
        ndone    = ndone + 1;
        done_cyc = k;
      end
      if (s_latch2 !== done2) latch_mis = latch_mis + 1;
      if (k == 259) busy259 = busy2;
      if (k > 259 && busy2 !== 1'b0) rebusy = 1'b1;
      prev_clk  = s_clk2;
      prev_data = s_data2;
    end
    seg_txt2 = pat;
  endtask

  task automatic wait_idle2();
    int n;
    n = 0;
    while (busy2 !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b required 0 within 400 cycles", busy2);
    end
  endtask

  task automatic test_reset();
    // Start is held high during reset, and reset must win.
    rst = 1'b1; start2 = 1'b1; start1 = 1'b0;
    seg_txt2 = PAT; seg_txt1 = 64'hFFFF_0000_AAAA_5555;
    tick();
    tick();
    n_checks++;
    if ({busy2, s_clk2, s_data2, s_clr_n2, s_latch2, done2} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_outputs: busy,s_clk,s_data,s_clr_n,s_latch,done=%b required 000100",
               {busy2, s_clk2, s_data2, s_clr_n2, s_latch2, done2});
    end
    n_checks++;
    if (flash2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flash: flash=%b required 1", flash2);
    end
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_div1: busy=%b required 0", busy1);
    end
    rst = 1'b0;
  endtask

  // Called right after test_reset. start2 is still high, so a transfer runs
  // while the flash pattern is checked.
  task automatic test_flash();
    logic exp;
    for (int i = 0; i < 16; i++) begin
      exp = ((i / 4) % 2 == 0);
      n_checks++;
      if (flash2 !== exp) begin
        n_fail++;
        $display("FAIL flash_pattern[%0d]: flash=%b required %b", i, flash2, exp);
      end
      tick();
      start2 = 1'b0;
    end
    n_checks++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL flash_fsm_active: busy=%b required 1", busy2);
    end
    wait_idle2();
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] got; int edges, dc, nd, lm, vi; logic b259; bit rb, cok;
    xfer2(PAT, 1'b0, 1'b0, got, edges, dc, nd, lm, vi, b259, rb, cok);
    n_checks++; if (!cok) begin n_fail++; $display("FAIL basic_clear: CLEAR levels wrong at N+1"); end
    n_checks++; if (edges !== 64) begin n_fail++; $display("FAIL basic_edges: got %0d required 64", edges); end
    n_checks++; if (got !== PAT) begin n_fail++; $display("FAIL basic_stream: got %h required %h", got, PAT); end
    n_checks++; if (dc !== 258 || nd !== 1) begin n_fail++; $display("FAIL basic_done: cycle %0d count %0d required 258/1", dc, nd); end
    n_checks++; if (lm !== 0) begin n_fail++; $display("FAIL basic_latch: %0d cycles s_latch!=done required 0", lm); end
    n_checks++; if (vi !== 0) begin n_fail++; $display("FAIL basic_data_stable: %0d illegal s_data changes required 0", vi); end
    n_checks++; if (b259 !== 1'b0) begin n_fail++; $display("FAIL basic_busy259: busy=%b required 0", b259); end
  endtask

  task automatic test_capture();
    logic [63:0] got; int edges, dc, nd, lm, vi; logic b259; bit rb, cok;
    xfer2(PAT, 1'b1, 1'b0, got, edges, dc, nd, lm, vi, b259, rb, cok);
    n_checks++; if (got !== PAT || edges !== 64) begin n_fail++; $display("FAIL capture_stream: got %h (%0d edges) required %h (64)", got, edges, PAT); end
    n_checks++; if (dc !== 258) begin n_fail++; $display("FAIL capture_done: cycle %0d required 258", dc); end
  endtask

  task automatic test_busy_start();
    logic [63:0] got; int edges, dc, nd, lm, vi; logic b259; bit rb, cok;
    xfer2(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, got, edges, dc, nd, lm, vi, b259, rb, cok);
    n_checks++; if (nd !== 1 || dc !== 258) begin n_fail++; $display("FAIL busystart_done: count %0d cycle %0d required 1/258", nd, dc); end
    n_checks++; if (b259 !== 1'b0) begin n_fail++; $display("FAIL busystart_busy259: busy=%b required 0", b259); end
    n_checks++; if (rb) begin n_fail++; $display("FAIL busystart_queued: busy=1 after 259 required 0"); end
    n_checks++; if (got !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL busystart_stream: got %h required 0123456789abcdef", got); end
  endtask

  task automatic test_midop_reset();
    logic [63:0] got; int edges, dc, nd, lm, vi; logic b259; bit rb, cok;
    int bad;
    seg_txt2 = PAT;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 2; k <= 50; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({s_clk2, s_clr_n2, busy2, done2, s_latch2} !== 5'b01000) begin
      n_fail++;
      $display("FAIL midrst_levels: s_clk,s_clr_n,busy,done,s_latch=%b required 01000",
               {s_clk2, s_clr_n2, busy2, done2, s_latch2});
    end
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done2 !== 1'b0 || s_latch2 !== 1'b0 || busy2 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL midrst_no_done: %0d active cycles required 0", bad); end
    xfer2(64'h1, 1'b0, 1'b0, got, edges, dc, nd, lm, vi, b259, rb, cok);
    n_checks++; if (got !== 64'h1 || edges !== 64) begin n_fail++; $display("FAIL midrst_stream: got %h (%0d edges) required 1 (64)", got, edges); end
    n_checks++; if (dc !== 258 || nd !== 1) begin n_fail++; $display("FAIL midrst_done: cycle %0d count %0d required 258/1", dc, nd); end
  endtask

  task automatic test_back_to_back();
    int len, gap, nd;
    start1 = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      len = 0; nd = 0;
      while (busy1 === 1'b1 && len < 400) begin
        if (done1 === 1'b1) nd++;
        len++;
        tick();
      end
      gap = 0;
      while (busy1 !== 1'b1 && gap < 10) begin
        gap++;
        tick();
      end
      n_checks++;
      if (len !== 130) begin n_fail++; $display("FAIL b2b_busy_len[%0d]: %0d required 130", r, len); end
      n_checks++;
      if (gap !== 1) begin n_fail++; $display("FAIL b2b_idle_gap[%0d]: %0d required 1", r, gap); end
      n_checks++;
      if (nd !== 1) begin n_fail++; $display("FAIL b2b_done_count[%0d]: %0d required 1", r, nd); end
    end
    start1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; start1 = 1'b0; seg_txt2 = '0; seg_txt1 = '0;
    test_reset();
    test_flash();
    test_basic();
    tick();
    test_capture();
    tick();
    test_busy_start();
    tick();
    test_midop_reset();
    tick();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_shift_ctrl.md
SEG_SHIFT_CTRL -- requirements
Module: seg_shift_ctrl

Interface
REQ-001 The module SHALL have parameter DIV, default 2, meaning s_clk half-period in clk cycles (legal range 1..255).
REQ-002 The module SHALL have parameter FLASH_DIV, default 25000000, meaning clk cycles per flash-output half-period.
REQ-003 The module SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port start  input  1  request to transfer seg_txt to the display shift chain.
REQ-006 The module SHALL have port seg_txt  input  64  segment image for 8 digits, 8 bits per digit, as produced by the hex-to-segment decoder.
REQ-007 The module SHALL have port s_clk  output  1  serial shift clock to the external shift-register chain.
REQ-008 The module SHALL have port s_data  output  1  serial data.
REQ-009 The module SHALL have port s_clr_n  output  1  chain clear, active-low.
REQ-010 The module SHALL have port s_latch  output  1  output-latch strobe, active-high.
REQ-011 The module SHALL have port busy  output  1  transfer in progress.
REQ-012 The module SHALL have port done  output  1  one-cycle pulse on transfer completion.
REQ-013 The module SHALL have port flash  output  1  blink enable, fed back to the decoder flash input.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, SHIFT and LATCH.
REQ-015 In IDLE, a start sampled high SHALL copy seg_txt into a 64-bit shift register and move to CLEAR; no other signal SHALL leave IDLE.
REQ-016 CLEAR SHALL last exactly 1 cycle with s_clr_n=0, then move to SHIFT.
REQ-017 SHIFT SHALL send 64 bits MSB first (bit 63 first, bit 0 last).
REQ-018 Each bit in SHIFT SHALL take 2*DIV cycles: s_clk=0 for DIV cycles, then s_clk=1 for DIV cycles.
REQ-019 s_data SHALL change only in the first cycle of a bit's s_clk-low phase, so it is stable across the rising edge of s_clk.
REQ-020 A 7-bit bit counter SHALL count the bits; after the 64th s_clk-high phase completes, the FSM SHALL move to LATCH.
REQ-021 LATCH SHALL last exactly 1 cycle with s_latch=1 and done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in CLEAR, SHIFT and LATCH, and 0 in IDLE.
REQ-023 Latency: if start is sampled at edge N, CLEAR SHALL occupy cycle N+1, SHIFT SHALL occupy cycles N+2 .. N+1+128*DIV, and LATCH/done SHALL occur in cycle N+2+128*DIV (258 for DIV=2).
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes to seg_txt after capture SHALL NOT affect the transfer in progress.
REQ-026 start held high continuously SHALL start a new transfer on the first IDLE cycle after each LATCH, giving back-to-back transfers with 1 idle cycle between them.
REQ-027 Idle output levels SHALL be: s_clk=0, s_data=0, s_clr_n=1, s_latch=0, done=0.
REQ-028 The flash counter SHALL run independently of the FSM, counting 0..FLASH_DIV-1 and toggling flash on wrap (period 2*FLASH_DIV cycles).

Reset
REQ-029 rst=1 at a clock edge SHALL force state=IDLE, shift register=0, bit counter=0, divider=0, flash counter=0, flash=1, and all other outputs to their idle levels.
REQ-030 rst SHALL take priority over start, including a start in the same cycle.
REQ-031 rst asserted mid-transfer SHALL abort the transfer with no done and no s_latch pulse; after rst deasserts, the next start SHALL run a complete, correct transfer.

Verification
REQ-032 Scenario (basic): DIV=2, seg_txt=64'hC0F9_A4B0_9992_82F8, pulse start -> exactly 64 s_clk rising edges, sampled bits equal bit 63..0 of the pattern, done in cycle N+258, s_latch coincident with done.
REQ-033 Scenario (capture): change seg_txt to all-ones 10 cycles after start -> serial stream still equals the originally captured value.
REQ-034 Scenario (busy start): pulse start again at cycle N+100 -> no restart, single done at N+258, busy=0 at N+259.
REQ-035 Scenario (mid-op reset): rst at cycle N+50 for 1 cycle -> s_clk=0, s_clr_n=1, busy=0 next cycle, no done; then start with 64'h0000_0000_0000_0001 -> 63 zeros then one 1, done as in REQ-032.
REQ-036 Scenario (continuous start): DIV=1, start held high -> transfers of 130 busy cycles each, separated by exactly 1 idle cycle.
REQ-037 Scenario (flash): FLASH_DIV=4 -> flash=1 after reset, toggles every 4 cycles (pattern 1111 0000 repeating), unaffected by FSM activity.
